// File: rtl/semafor_pkg.sv
// Shared definitions for the pedestrian request front-end of the semafor controller.
// Contents:
//   stare_e          - request FSM state encoding (2 bits, visible on the debug port)
//   DEBOUNCE_CYC_DEF - default debounce length in synchronised samples
//   LOCKOUT_CYC_DEF  - default lockout length in clock cycles after service
package semafor_pkg;

    typedef enum logic [1:0] {
        LIBER   = 2'd0,
        CERERE  = 2'd1,
        SERVIRE = 2'd2,
        BLOCARE = 2'd3
    } stare_e;

    localparam int unsigned DEBOUNCE_CYC_DEF = 2;
    localparam int unsigned LOCKOUT_CYC_DEF  = 3;

endpackage

// File: rtl/cerere_pietoni_if.sv
// Pedestrian request bundle between the button front-end and the semafor controller.
// Signals:
//   buton         - raw push-button level (asynchronous, may bounce)
//   ack           - controller is serving the pedestrian phase
//   cerere        - clean request level to the controller
//   led_asteptare - "wait" lamp
//   nr_apasari    - accepted presses in the current request (saturating)
//   stare         - request FSM state, for debug
// Modports: master = controller/stimulus side, slave = request front-end.
interface cerere_pietoni_if #(
    parameter int unsigned CNT_W = 4
);
    logic             buton;
    logic             ack;
    logic             cerere;
    logic             led_asteptare;
    logic [CNT_W-1:0] nr_apasari;
    logic [1:0]       stare;

    modport master (
        output buton, ack,
        input  cerere, led_asteptare, nr_apasari, stare
    );

    modport slave (
        input  buton, ack,
        output cerere, led_asteptare, nr_apasari, stare
    );
endinterface

// File: rtl/filtru_buton.sv
// Button conditioning: 2-flop synchroniser, debounce filter and rising-edge detect.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   buton   - raw asynchronous button level
//   apasare - one-cycle pulse when the filtered level rises
module filtru_buton #(
    parameter int unsigned DEBOUNCE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic buton,
    output logic apasare
);
    localparam int unsigned DbW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

    logic           buton_m;   // first synchroniser stage, may go metastable
    logic           buton_s;
    logic           buton_f;   // debounced level
    logic           buton_f_q; // debounced level one cycle earlier
    logic [DbW-1:0] cnt_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            buton_m   <= 1'b0;
            buton_s   <= 1'b0;
            buton_f   <= 1'b0;
            buton_f_q <= 1'b0;
            cnt_db    <= '0;
        end else begin
            buton_m   <= buton;
            buton_s   <= buton_m;
            buton_f_q <= buton_f;
            // A new level is accepted only after DEBOUNCE_CYC consecutive differing samples.
            if (buton_s == buton_f) begin
                cnt_db <= '0;
            end else if (cnt_db == DbLast) begin
                buton_f <= buton_s;
                cnt_db  <= '0;
            end else begin
                cnt_db <= cnt_db + 1'b1;
            end
        end
    end

    assign apasare = buton_f & ~buton_f_q;

endmodule

// File: rtl/cerere_pietoni.sv
// Pedestrian request front-end: holds a clean request until the controller serves it,
// then locks out new presses for LOCKOUT_CYC cycles.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - cerere_pietoni_if.slave (buton, ack in; cerere, led_asteptare, nr_apasari, stare out)
module cerere_pietoni
    import semafor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned LOCKOUT_CYC  = LOCKOUT_CYC_DEF,
    parameter int unsigned CNT_W        = 4
) (
    input logic             clk,
    input logic             rst,
    cerere_pietoni_if.slave bus
);
    localparam int unsigned LockW = (LOCKOUT_CYC < 2) ? 1 : $clog2(LOCKOUT_CYC + 1);
    localparam logic [CNT_W-1:0] NrMax = '1;

    logic             apasare;
    stare_e           state_q;
    logic             cerere_q;
    logic             led_q;
    logic [CNT_W-1:0] nr_q;
    logic [LockW-1:0] lock_q;

    filtru_buton #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_filtru (
        .clk    (clk),
        .rst    (rst),
        .buton  (bus.buton),
        .apasare(apasare)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LIBER;
            cerere_q <= 1'b0;
            led_q    <= 1'b0;
            nr_q     <= '0;
            lock_q   <= '0;
        end else begin
            unique case (state_q)
                LIBER: begin
                    if (apasare) begin
                        state_q  <= CERERE;
                        cerere_q <= 1'b1;
                        led_q    <= 1'b1;
                        nr_q     <= CNT_W'(1);
                    end
                end
                CERERE: begin
                    // ack takes priority; a press in the same cycle is dropped.
                    if (bus.ack) begin
                        state_q  <= SERVIRE;
                        cerere_q <= 1'b0;
                    end else if (apasare && nr_q != NrMax) begin
                        nr_q <= nr_q + 1'b1;
                    end
                end
                SERVIRE: begin
                    if (!bus.ack) begin
                        led_q <= 1'b0;
                        if (LOCKOUT_CYC == 0) begin
                            state_q <= LIBER;
                        end else begin
                            state_q <= BLOCARE;
                            lock_q  <= LockW'(LOCKOUT_CYC);
                        end
                    end
                end
                BLOCARE: begin
                    if (lock_q <= LockW'(1)) begin
                        state_q <= LIBER;
                    end else begin
                        lock_q <= lock_q - 1'b1;
                    end
                end
                default: state_q <= LIBER;
            endcase
        end
    end

    assign bus.cerere        = cerere_q;
    assign bus.led_asteptare = led_q;
    assign bus.nr_apasari    = nr_q;
    assign bus.stare         = state_q;

endmodule

// File: tb/tb_cerere_pietoni.sv
// Self-checking bench for cerere_pietoni: directed scenarios plus random button/ack/reset
// traffic, every output compared each cycle against a behavioural model.
module tb_cerere_pietoni;
    import semafor_pkg::*;

    localparam int unsigned DB   = DEBOUNCE_CYC_DEF;
    localparam int unsigned LOCK = LOCKOUT_CYC_DEF;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cerere_pietoni_if #(.CNT_W(CW)) bus ();

    cerere_pietoni #(
        .DEBOUNCE_CYC(DB),
        .LOCKOUT_CYC (LOCK),
        .CNT_W       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model. The filtered level flips once the button, seen two edges late,
    // has disagreed with it for DB samples in a row. A press is a rise of the filtered level,
    // acted on one edge later. Mode: 0 idle, 1 requesting, 2 served, 3 lockout.
    logic raw_hist[$];
    bit   filt, filt_prev;
    int   streak, mode, count, left;
    bit   chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit press;
        bit smp;
        if (rst) begin
            raw_hist.delete();
            raw_hist.push_back(1'b0);
            raw_hist.push_back(1'b0);
            filt = 0; filt_prev = 0; streak = 0;
            mode = 0; count = 0; left = 0;
        end else begin
            press = filt && !filt_prev;
            case (mode)
                0: if (press) begin mode = 1; count = 1; end
                1: if (bus.ack) mode = 2;
                   else if (press && count < CMAX) count++;
                2: if (!bus.ack) begin
                       if (LOCK == 0) mode = 0;
                       else begin mode = 3; left = LOCK; end
                   end
                default: if (left == 1) mode = 0; else left--;
            endcase
            filt_prev = filt;
            smp = raw_hist.pop_front();
            raw_hist.push_back(bus.buton);
            if (smp != filt) begin
                streak++;
                if (streak >= DB) begin filt = smp; streak = 0; end
            end else begin
                streak = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_cerere", bus.cerere, (mode == 1));
            check("m_led", bus.led_asteptare, (mode == 1 || mode == 2));
            check("m_nr", bus.nr_apasari, count);
            check("m_stare", bus.stare, mode);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apasa(input int hi, input int lo);
        bus.buton = 1'b1;
        cycles(hi);
        bus.buton = 1'b0;
        cycles(lo);
    endtask

    initial begin
        rst = 1'b1; bus.buton = 1'bx; bus.ack = 1'b0;

        // Reset with unknown button, then two reset edges.
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_cerere", bus.cerere, 0);
        check("rst_led", bus.led_asteptare, 0);
        check("rst_nr", bus.nr_apasari, 0);
        check("rst_stare", bus.stare, LIBER);
        bus.buton = 1'b0;
        @(negedge clk);
        check("rst_hold", bus.stare, LIBER);
        rst = 1'b0;
        cycles(3);

        // One-cycle glitch must not produce a request.
        bus.buton = 1'b1;
        cycles(1);
        bus.buton = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("glitch_stare", bus.stare, LIBER);
        end

        // Clean press: request appears exactly DB+2 edges after the first sampling edge.
        bus.buton = 1'b1;
        for (int i = 0; i < DB + 2; i++) begin
            @(negedge clk);
            check("lat_early", bus.cerere, 0);
        end
        @(negedge clk);
        check("lat_cerere", bus.cerere, 1);
        check("lat_led", bus.led_asteptare, 1);
        check("lat_nr", bus.nr_apasari, 1);
        cycles(1);
        bus.buton = 1'b0;
        cycles(6);

        // More presses, then saturation.
        repeat (3) apasa(6, 6);
        check("nr_four", bus.nr_apasari, 4);
        repeat (20) apasa(6, 6);
        check("nr_sat", bus.nr_apasari, CMAX);

        // Handshake and lockout; a press during service/lockout is swallowed.
        bus.ack = 1'b1;
        @(negedge clk);
        check("ack_cerere", bus.cerere, 0);
        check("ack_led", bus.led_asteptare, 1);
        check("ack_stare", bus.stare, SERVIRE);
        bus.buton = 1'b1;
        @(negedge clk);
        check("ack_led2", bus.led_asteptare, 1);
        bus.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lock_stare", bus.stare, BLOCARE);
            check("lock_led", bus.led_asteptare, 0);
        end
        bus.buton = 1'b0;
        @(negedge clk);
        check("lock_end", bus.stare, LIBER);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("lock_nopress", bus.cerere, 0);
            check("lock_nrhold", bus.nr_apasari, CMAX);
        end

        // Reset mid-request with the button held across it.
        apasa(6, 6);
        check("pre_rst_req", bus.cerere, 1);
        bus.buton = 1'b1;
        cycles(3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cerere", bus.cerere, 0);
        check("mid_rst_led", bus.led_asteptare, 0);
        check("mid_rst_nr", bus.nr_apasari, 0);
        check("mid_rst_stare", bus.stare, LIBER);
        rst = 1'b0;
        for (int i = 0; i < DB + 2; i++) begin
            @(negedge clk);
            check("held_early", bus.cerere, 0);
        end
        @(negedge clk);
        check("held_cerere", bus.cerere, 1);
        bus.buton = 1'b0;
        cycles(6);

        // Random traffic, including short glitches, short acks and occasional resets.
        for (int i = 0; i < 300; i++) begin
            bus.buton = 1'($urandom_range(0, 1));
            bus.ack   = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycles($urandom_range(1, 8));
        end
        rst = 1'b0; bus.buton = 1'b0; bus.ack = 1'b0;
        cycles(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
